ui_sensor_pix_capture: RTL

//  Parametrised DVP camera capture front end; next generation of the RGB565 capture block.

---
 rtl/ui_sensor_pkg.sv | 39 +++
 rtl/ui_sensor_pix_unpack.sv | 63 ++++++
 rtl/ui_sensor_pix_capture.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ui_sensor_pkg.sv
// Shared types and the pixel-word to RGB888 expansion used by the DVP capture path.
package ui_sensor_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RGB555 = 2'd1,
    MODE_GREY8  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // lsb_rep: fill the low bits of each 8-bit channel with that channel's MSBs instead of zeros.
  function automatic logic [23:0] pix_to_rgb888(input mode_e mode, input logic [15:0] word,
                                                input logic lsb_rep);
    logic [7:0] r8, g8, b8;
    r8 = '0;
    g8 = '0;
    b8 = '0;
    case (mode)
      MODE_RGB565: begin
        r8 = {word[15:11], lsb_rep ? word[15:13] : 3'b000};
        g8 = {word[10:5],  lsb_rep ? word[10:9]  : 2'b00};
        b8 = {word[4:0],   lsb_rep ? word[4:2]   : 3'b000};
      end
      MODE_RGB555: begin
        r8 = {word[14:10], lsb_rep ? word[14:12] : 3'b000};
        g8 = {word[9:5],   lsb_rep ? word[9:7]   : 3'b000};
        b8 = {word[4:0],   lsb_rep ? word[4:2]   : 3'b000};
      end
      MODE_GREY8: begin
        r8 = word[7:0];
        g8 = word[7:0];
        b8 = word[7:0];
      end
      default: ;
    endcase
    return {r8, g8, b8};
  endfunction

endpackage

// File: rtl/ui_sensor_pix_unpack.sv
// Beat-to-pixel assembly (1 or 2 beats per pixel) and RGB888 expansion of the assembled word.
module ui_sensor_pix_unpack
  import ui_sensor_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BYTE_SWAP     = 0,
  parameter int LSB_REPLICATE = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vs_p,
  input  logic        i_href,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_mode,
  output logic        o_vld,
  output logic        o_phase,
  output logic [23:0] o_rgb
);

  logic        r_phase;
  logic        r_vld;
  logic [7:0]  r_hold;
  logic [15:0] r_word;
  mode_e       w_mode;
  logic        w_two_beat;

  always_comb begin
    w_mode     = mode_e'(i_mode);
    w_two_beat = (DATA_W == 8) && ((w_mode == MODE_RGB565) || (w_mode == MODE_RGB555));
  end

  // A frame start discards whatever beat arrives with it, even if href is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
      r_vld   <= 1'b0;
      r_hold  <= '0;
      r_word  <= '0;
    end else begin
      r_vld <= 1'b0;
      if (i_vs_p || !i_href) begin
        r_phase <= 1'b0;
      end else if (w_two_beat) begin
        if (!r_phase) begin
          r_hold  <= i_data[7:0];
          r_phase <= 1'b1;
        end else begin
          r_word  <= (BYTE_SWAP != 0) ? {i_data[7:0], r_hold} : {r_hold, i_data[7:0]};
          r_vld   <= 1'b1;
          r_phase <= 1'b0;
        end
      end else begin
        r_word <= i_data;
        r_vld  <= (w_mode != MODE_RSVD);
      end
    end
  end

  assign o_vld   = r_vld;
  assign o_phase = r_phase;
  assign o_rgb   = pix_to_rgb888(w_mode, r_word, LSB_REPLICATE != 0);

endmodule

// File: rtl/ui_sensor_pix_capture.sv
// DVP camera capture front end: input sync, start-up frame skip, unpack to RGB888 video timing.
// Optional frame statistics built when SENSOR_FRAME_STATS_EN is defined.
module ui_sensor_pix_capture
  import ui_sensor_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int FRAME_SKIP    = 5,
  parameter int VSYNC_ACT_LOW = 1,
  parameter int BYTE_SWAP     = 0,
  parameter int LSB_REPLICATE = 0
) (
  input  logic              cmos_pclk_i,
  input  logic              rstn_i,
  input  logic              cmos_clk_i,
  output logic              cmos_xclk_o,
  input  logic              cmos_href_i,
  input  logic              cmos_vsync_i,
  input  logic [DATA_W-1:0] cmos_data_i,
  input  logic [1:0]        mode_i,
  output logic [23:0]       rgb_o,
  output logic              de_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic [15:0]       frame_cnt_o,
  output logic [15:0]       frame_w_o,
  output logic [15:0]       frame_h_o,
  output logic              stat_vld_o,
  output logic              line_err_o
);

  localparam logic [7:0] SKIP_DONE = 8'(FRAME_SKIP + 1);

  logic              r_href_s1, r_href_s2, r_href_s3;
  logic              r_vs_s1, r_vs_s2, r_vs_s3;
  logic [DATA_W-1:0] r_data_s1, r_data_s2;
  logic [7:0]        r_skip_cnt;
  logic [15:0]       r_frame_cnt;
  mode_e             r_mode;
  logic              w_vs_p, w_out_en, w_vld, w_phase;
  logic [23:0]       w_rgb;

  assign cmos_xclk_o = cmos_clk_i;

  // Third stage is unreset too, so releasing reset mid-frame never fakes a frame-start edge.
  always_ff @(posedge cmos_pclk_i) begin
    r_href_s1 <= cmos_href_i;
    r_vs_s1   <= (VSYNC_ACT_LOW != 0) ? ~cmos_vsync_i : cmos_vsync_i;
    r_data_s1 <= cmos_data_i;
    r_href_s2 <= r_href_s1;
    r_vs_s2   <= r_vs_s1;
    r_data_s2 <= r_data_s1;
    r_href_s3 <= r_href_s2;
    r_vs_s3   <= r_vs_s2;
  end

  assign w_vs_p   = r_vs_s2 & ~r_vs_s3;
  assign w_out_en = (r_skip_cnt == SKIP_DONE);

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_skip_cnt  <= '0;
      r_frame_cnt <= '0;
      r_mode      <= MODE_RGB565;
    end else if (w_vs_p) begin
      if (r_skip_cnt != SKIP_DONE) r_skip_cnt <= r_skip_cnt + 8'd1;
      if (r_skip_cnt >= 8'(FRAME_SKIP)) r_frame_cnt <= r_frame_cnt + 16'd1;
      r_mode <= mode_e'(mode_i);
    end
  end

  ui_sensor_pix_unpack #(
    .DATA_W       (DATA_W),
    .BYTE_SWAP    (BYTE_SWAP),
    .LSB_REPLICATE(LSB_REPLICATE)
  ) u_unpack (
    .i_clk  (cmos_pclk_i),
    .i_rst_n(rstn_i),
    .i_vs_p (w_vs_p),
    .i_href (r_href_s2),
    .i_data (16'(r_data_s2)),
    .i_mode (r_mode),
    .o_vld  (w_vld),
    .o_phase(w_phase),
    .o_rgb  (w_rgb)
  );

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o <= '0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
    end else begin
      de_o <= w_vld & w_out_en;
      hs_o <= r_href_s3 & w_out_en;
      vs_o <= r_vs_s3 & w_out_en;
      if (w_vld && w_out_en) rgb_o <= w_rgb;
    end
  end

  assign frame_cnt_o = r_frame_cnt;

`ifdef SENSOR_FRAME_STATS_EN
  logic [15:0] r_pix_cnt, r_last_w, r_line_cnt, r_frame_w, r_frame_h;
  logic        r_stat_vld, r_line_err;
  logic        w_line_end, w_line_start;

  // Line end is seen at stage 3, where the unpack valid for the line's last pixel also sits.
  assign w_line_end   = r_href_s3 & ~r_href_s2;
  assign w_line_start = r_href_s2 & ~r_href_s3;

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pix_cnt  <= '0;
      r_last_w   <= '0;
      r_line_cnt <= '0;
      r_frame_w  <= '0;
      r_frame_h  <= '0;
      r_stat_vld <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_stat_vld <= w_vs_p;
      r_line_err <= w_line_end & w_phase;
      if (w_line_end) begin
        r_last_w  <= r_pix_cnt + 16'(w_vld);
        r_pix_cnt <= '0;
      end else if (w_vld) begin
        r_pix_cnt <= r_pix_cnt + 16'd1;
      end
      if (w_vs_p) begin
        r_frame_w  <= r_last_w;
        r_frame_h  <= r_line_cnt;
        r_line_cnt <= w_line_start ? 16'd1 : 16'd0;
      end else if (w_line_start) begin
        r_line_cnt <= r_line_cnt + 16'd1;
      end
    end
  end

  assign frame_w_o  = r_frame_w;
  assign frame_h_o  = r_frame_h;
  assign stat_vld_o = r_stat_vld;
  assign line_err_o = r_line_err;
`else
  assign frame_w_o  = '0;
  assign frame_h_o  = '0;
  assign stat_vld_o = 1'b0;
  assign line_err_o = 1'b0;
`endif

endmodule
